// File: rtl/lsu_pkg.sv
// Shared definitions for the MA-stage load/store unit: op codes, FSM state
// encoding and small decode helpers used by ma_lsu and lsu_align.
package lsu_pkg;

    localparam logic [2:0] LSU_LB  = 3'd0;
    localparam logic [2:0] LSU_LH  = 3'd1;
    localparam logic [2:0] LSU_LW  = 3'd2;
    localparam logic [2:0] LSU_LBU = 3'd3;
    localparam logic [2:0] LSU_LHU = 3'd4;
    localparam logic [2:0] LSU_SB  = 3'd5;
    localparam logic [2:0] LSU_SH  = 3'd6;
    localparam logic [2:0] LSU_SW  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    function automatic logic is_store(input logic [2:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic is_unsigned(input logic [2:0] op);
        return (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    function automatic lsu_size_e op_size(input logic [2:0] op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return SZ_BYTE;
            LSU_LH, LSU_LHU, LSU_SH: return SZ_HALF;
            default:                 return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: misalign detect, store byte enables and
// lane replication, and big-endian load lane selection with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_op,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] ld_data
);

    // Request side: alignment check and store lane steering.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        lane_wdata = req_wdata;
        case (op_size(req_op))
            SZ_HALF: misaligned = req_off[0];
            SZ_WORD: misaligned = |req_off;
            default: misaligned = 1'b0;
        endcase
        if (is_store(req_op)) begin
            case (op_size(req_op))
                SZ_BYTE: begin
                    be         = 4'b1000 >> req_off;
                    lane_wdata = {4{req_wdata[7:0]}};
                end
                SZ_HALF: begin
                    be         = req_off[1] ? 4'b0011 : 4'b1100;
                    lane_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    be         = 4'b1111;
                    lane_wdata = req_wdata;
                end
            endcase
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Response side: byte offset 0 lives in the most significant lane.
    always_comb begin
        ld_byte = 8'h00;
        case (ld_off)
            2'd0:    ld_byte = ld_word[31:24];
            2'd1:    ld_byte = ld_word[23:16];
            2'd2:    ld_byte = ld_word[15:8];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = ld_off[1] ? ld_word[15:0] : ld_word[31:16];
        case (op_size(ld_op))
            SZ_BYTE: ld_data = is_unsigned(ld_op) ? {24'h000000, ld_byte}
                                                  : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = is_unsigned(ld_op) ? {16'h0000, ld_half}
                                                  : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/ma_lsu.sv
// MA-stage load/store unit: IDLE -> REQ -> DONE handshake with a variable-latency
// data memory. Define LSU_TIMEOUT_EN to abort a REQ after TIMEOUT_CYCLES cycles.
module ma_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  state;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic        misaligned;
    logic [3:0]  be_c;
    logic [31:0] lane_wdata_c;
    logic [31:0] ld_data_c;
    logic        to_hit;

    lsu_align u_align (
        .req_op     (req_op),
        .req_off    (addr[1:0]),
        .req_wdata  (wdata),
        .ld_op      (op_q),
        .ld_off     (off_q),
        .ld_word    (mem_rdata),
        .misaligned (misaligned),
        .be         (be_c),
        .lane_wdata (lane_wdata_c),
        .ld_data    (ld_data_c)
    );

    assign busy     = (state == ST_IDLE) ? (req_valid & ~misaligned) : (state == ST_REQ);
    assign misalign = (state == ST_IDLE) & req_valid & misaligned;
    assign mem_req  = (state == ST_REQ);
    assign done     = (state == ST_DONE);

`ifdef LSU_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // The counter sits at zero outside REQ, so it is clear on every REQ entry;
    // an ack in the final counted cycle takes priority over the abort.
    assign to_hit  = (state == ST_REQ) & ~mem_ack & ((to_cnt + 1'b1) == TO_W'(TIMEOUT_CYCLES));
    assign bus_err = err_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= to_hit;
            if ((state == ST_REQ) && !mem_ack)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Main FSM; the memory-side fields are captured once at accept and held
    // unchanged for the whole REQ phase.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= ST_IDLE;
            op_q      <= LSU_LB;
            off_q     <= 2'd0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            rdata_out <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && !misaligned) begin
                        op_q      <= req_op;
                        off_q     <= addr[1:0];
                        mem_we    <= is_store(req_op);
                        mem_be    <= be_c;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wdata <= lane_wdata_c;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (!is_store(op_q))
                            rdata_out <= ld_data_c;
                        state <= ST_DONE;
                    end else if (to_hit) begin
                        rdata_out <= 32'h0;
                        state     <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ma_lsu.sv
// Directed testbench for ma_lsu: per-cycle expectations from a transaction-level
// model, one negedge compare process, and literal pins for the headline vectors.
module tb_ma_lsu;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, misalign, bus_err;
    logic [31:0] rdata_out;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int compared   = 0;
    int mismatched = 0;

    bit          chkEn = 0;
    bit          memChk, wdChk;
    logic        expBusy, expDone, expMis, expErr, expReq, expWe;
    logic [3:0]  expBe;
    logic [31:0] expAddr, expWdata, expRdata;

    logic        smpWe;
    logic [3:0]  smpBe;
    logic [31:0] smpAddr, smpWdata;

    ma_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_op    (req_op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata_out (rdata_out),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: operand size in bytes, derived from the op code table.
    function automatic int sizeOf(input logic [2:0] op);
        if (op == 0 || op == 3 || op == 5) return 1;
        if (op == 1 || op == 4 || op == 6) return 2;
        return 4;
    endfunction

    function automatic bit isMis(input logic [2:0] op, input logic [31:0] a);
        return (a % sizeOf(op)) != 0;
    endfunction

    function automatic logic [31:0] loadVal(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        int unsigned off = a % 4;
        logic [31:0] v;
        if (sizeOf(op) == 1) begin
            v = (w >> (8 * (3 - off))) & 32'hFF;
            if (op == 0 && v > 127) v = v | 32'hFFFFFF00;
        end else if (sizeOf(op) == 2) begin
            v = (w >> (16 - 8 * off)) & 32'hFFFF;
            if (op == 1 && v > 32767) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] storeBe(input logic [2:0] op, input logic [31:0] a);
        int unsigned off = a % 4;
        if (op == 5) return 4'(1 << (3 - off));
        if (op == 6) return (off == 0) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] storeData(input logic [2:0] op, input logic [31:0] d);
        if (op == 5) return (d & 32'hFF) * 32'h01010101;
        if (op == 6) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // Compare the DUT against the current-cycle expectations, away from the edge.
    always @(negedge CLK) begin
        if (chkEn) begin
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("done", 32'(done), 32'(expDone));
            checkOutput("misalign", 32'(misalign), 32'(expMis));
            checkOutput("bus_err", 32'(bus_err), 32'(expErr));
            checkOutput("mem_req", 32'(mem_req), 32'(expReq));
            checkOutput("rdata_out", rdata_out, expRdata);
            if (memChk) begin
                checkOutput("mem_we", 32'(mem_we), 32'(expWe));
                checkOutput("mem_be", 32'(mem_be), 32'(expBe));
                checkOutput("mem_addr", mem_addr, expAddr);
            end
            if (wdChk)
                checkOutput("mem_wdata", mem_wdata, expWdata);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic setIdle();
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        expBusy = 0; expDone = 0; expMis = 0; expErr = 0; expReq = 0;
        memChk = 0; wdChk = 0;
    endtask

    // Drive one access; ack arrives in REQ cycle ackDelay; resetAt>0 pulls
    // RST low during that REQ cycle instead of completing.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] word, input int ackDelay, input int resetAt);
        int  complete;
        bit  timedOut;
        bit  aborted;
        tick();
        req_valid = 1'b1; req_op = op; addr = a; wdata = d; mem_ack = 1'b0;
        expDone = 0; expErr = 0; expReq = 0; memChk = 0; wdChk = 0;
        expMis  = isMis(op, a);
        expBusy = !isMis(op, a);
        if (isMis(op, a)) begin
            tick();
            setIdle();
            return;
        end
        complete = ackDelay;
        timedOut = 0;
`ifdef LSU_TIMEOUT_EN
        if (ackDelay > TO) begin
            complete = TO;
            timedOut = 1;
        end
`endif
        aborted = 0;
        for (int i = 1; i <= complete && !aborted; i++) begin
            tick();
            if (resetAt == i) RST = 1'b0;
            mem_ack = (i == ackDelay); mem_rdata = word;
            expMis = 0; expBusy = 1; expReq = 1; memChk = 1; wdChk = (op >= 5);
            expWe = (op >= 5); expBe = storeBe(op, a); expAddr = a & 32'hFFFFFFFC;
            expWdata = storeData(op, d);
            if (i == 1) begin
                @(negedge CLK);
                #1;
                smpWe = mem_we; smpBe = mem_be; smpAddr = mem_addr; smpWdata = mem_wdata;
            end
            if (resetAt == i) aborted = 1;
        end
        if (aborted) begin
            tick();
            RST = 1'b1;
            setIdle();
            memChk = 1; wdChk = 1;
            expWe = 0; expBe = 4'h0; expAddr = 32'h0; expWdata = 32'h0; expRdata = 32'h0;
            tick();
            setIdle();
            return;
        end
        tick();
        mem_ack = 1'b0; expReq = 0; memChk = 0; wdChk = 0; expBusy = 0;
        expDone = 1; expErr = timedOut;
        if (timedOut) expRdata = 32'h0;
        else if (op < 5) expRdata = loadVal(op, a, word);
        tick();
        setIdle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RST = 1'b0; req_op = 3'd0; addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0;
        setIdle();
        memChk = 1; wdChk = 1; expWe = 0; expBe = 4'h0; expAddr = 32'h0; expWdata = 32'h0;
        expRdata = 32'h0;
        tick();
        chkEn = 1;
        tick();
        RST = 1'b1;
        setIdle();

        applyStimulus(3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0);
        checkOutput("pin_lw_be", 32'(smpBe), 32'hF);
        checkOutput("pin_lw_addr", smpAddr, 32'h100);
        checkOutput("pin_lw_rdata", rdata_out, 32'hDEADBEEF);

        applyStimulus(3'd0, 32'h103, 32'h0, 32'h123456F0, 1, 0);
        checkOutput("pin_lb_rdata", rdata_out, 32'hFFFFFFF0);
        applyStimulus(3'd3, 32'h103, 32'h0, 32'h123456F0, 2, 0);
        checkOutput("pin_lbu_rdata", rdata_out, 32'h000000F0);

        applyStimulus(3'd6, 32'h202, 32'h0000ABCD, 32'h55555555, 1, 0);
        checkOutput("pin_sh_we", 32'(smpWe), 32'h1);
        checkOutput("pin_sh_be", 32'(smpBe), 32'h3);
        checkOutput("pin_sh_wdata", smpWdata, 32'hABCDABCD);
        checkOutput("pin_sh_addr", smpAddr, 32'h200);
        checkOutput("pin_sh_rdata_kept", rdata_out, 32'h000000F0);

        applyStimulus(3'd2, 32'h101, 32'h0, 32'h0, 1, 0);
        applyStimulus(3'd1, 32'h103, 32'h0, 32'h0, 1, 0);
        applyStimulus(3'd6, 32'h201, 32'h1234, 32'h0, 1, 0);

        applyStimulus(3'd1, 32'h100, 32'h0, 32'h80017FFF, 1, 0);
        checkOutput("pin_lh_rdata", rdata_out, 32'hFFFF8001);
        applyStimulus(3'd4, 32'h102, 32'h0, 32'hFFFF8001, 3, 0);
        checkOutput("pin_lhu_rdata", rdata_out, 32'h00008001);
        applyStimulus(3'd5, 32'h101, 32'h123456A5, 32'h0, 2, 0);
        checkOutput("pin_sb_be", 32'(smpBe), 32'h4);
        checkOutput("pin_sb_wdata", smpWdata, 32'hA5A5A5A5);
        applyStimulus(3'd7, 32'h300, 32'hCAFEF00D, 32'h0, 1, 0);
        applyStimulus(3'd6, 32'h200, 32'h00001357, 32'h0, 1, 0);
        applyStimulus(3'd0, 32'h101, 32'h0, 32'h00700000, 1, 0);
        checkOutput("pin_lb_pos", rdata_out, 32'h00000070);

        applyStimulus(3'd2, 32'h400, 32'h0, 32'hCAFEF00D, 5, 0);
        applyStimulus(3'd2, 32'h404, 32'h0, 32'h11111111, 8, 3);
        checkOutput("pin_reset_rdata", rdata_out, 32'h0);

`ifdef LSU_TIMEOUT_EN
        applyStimulus(3'd2, 32'h500, 32'h0, 32'h22222222, 10, 0);
        applyStimulus(3'd2, 32'h504, 32'h0, 32'h33333333, TO, 0);
        checkOutput("pin_ack_wins", rdata_out, 32'h33333333);
`else
        applyStimulus(3'd2, 32'h500, 32'h0, 32'h22222222, 20, 0);
        checkOutput("pin_long_wait", rdata_out, 32'h22222222);
`endif

        tick();
        chkEn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ma_lsu.md
Name: ma_lsu

Overview:
- Multi-cycle load/store unit between the MA stage datapath and a handshaked data memory with variable latency.
- Accepts one access per request. Uses the EX Result as the address and Rdata2 as the store data.
- Drives a word-wide memory bus with byte enables and stalls the core through `busy` until the access completes.
- Returns the aligned, sign- or zero-extended load data that feeds Wdata selection.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed in REQ before abort. Used only when LSU_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous reset, active-low
- req_valid  in  1  access requested this cycle
- req_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
- addr  in  32  byte address (EX Result)
- wdata  in  32  store data (Rdata2, right-justified)
- busy  out  1  stall request to core
- done  out  1  one-cycle completion pulse
- rdata_out  out  32  extended load data, valid while done=1
- misalign  out  1  misaligned request rejected
- bus_err  out  1  access aborted by timeout
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables; be[3] = byte at addr[1:0]=0
- mem_addr  out  32  word address, addr[1:0] forced to 0
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory accepted/completed, sampled only while mem_req=1
- mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-low. RST=0 at a rising edge gives:
  - state IDLE;
  - mem_req, mem_we, done, bus_err, rdata_out, mem_be, mem_addr, mem_wdata all 0.
  - An in-flight access is abandoned with no completion pulse.
- Endianness: big-endian. Byte offset 0 is bits [31:24].
- Misalignment rule:
  - LH/LHU/SH need addr[0]=0.
  - LW/SW need addr[1:0]=0.
  - Byte ops are never misaligned.
- State IDLE:
  - `busy` = req_valid & ~misaligned (combinational).
  - `misalign` = req_valid & misaligned (combinational). No memory access and no state change on a misaligned request.
  - A valid, aligned request latches op, addr, lanes and store data, then moves to REQ.
- State REQ:
  - mem_req=1 with registered mem_we, mem_be, mem_addr, mem_wdata, all stable until ack.
  - busy=1.
  - On mem_ack: capture and extend mem_rdata, then go to DONE.
- State DONE (one cycle):
  - done=1, busy=0, rdata_out valid. rdata_out holds its value until the next completion or reset.
  - req_valid is ignored here, because the same instruction is still presented.
  - Next state is always IDLE.
- Latency:
  - Accept at cycle 0, mem_req from cycle 1, ack in cycle k≥1, done in cycle k+1.
  - Zero-wait memory gives 2 busy cycles.
- Store lanes (mem_wdata / mem_be):
  - SB: byte replicated ×4; be one-hot = 4'b1000 >> addr[1:0].
  - SH: halfword replicated ×2; be = 1100 or 0011.
  - SW: be = 1111.
- Stores: rdata_out is unchanged, done still pulses.
- Loads:
  - mem_be = 1111.
  - Select the lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - 8+ bit counter (≥ clog2(TIMEOUT_CYCLES+1)) clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, go to DONE with bus_err=1 (for the DONE cycle only) and rdata_out=0.
  - An ack arriving in that same cycle wins: normal completion.
- Undefined: no counter, bus_err tied 0, REQ waits indefinitely.

Decomposition:
- Shared package lsu_pkg:
  - op code constants (LSU_LB … LSU_SW);
  - state encoding (IDLE/REQ/DONE);
  - is_store / is_unsigned / size helper constants.
- Combinational sub-module lsu_align: byte-lane steering, byte enables, extension, misalign detect.
- ma_lsu holds the FSM, registers and timeout.

Test Plan:
1. LW addr=0x100, memory word 0xDEADBEEF, ack 1 cycle after mem_req → mem_be=1111, mem_addr=0x100, done in cycle 2, rdata_out=0xDEADBEEF.
2. LB addr=0x103 with word 0x123456F0 → rdata_out=0xFFFFFFF0; LBU same address → 0x000000F0.
3. SH addr=0x202, wdata=0x0000ABCD → mem_we=1, mem_be=0011, mem_wdata=0xABCDABCD, mem_addr=0x200; rdata_out unchanged.
4. LW addr=0x101 → misalign=1 the same cycle, busy=0, mem_req never asserted, state stays IDLE.
5. Ack delayed 5 cycles → mem_req and outputs stable for all 5 cycles; RST=0 asserted mid-REQ → next cycle mem_req=0, no done pulse.
6. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → mem_req drops after 4 REQ cycles, done=1, bus_err=1, rdata_out=0.
